nand_sweep_checker: RTL

Self-checking exhaustive stimulus generator and response checker for N-input NAND/AND cells. On `start` it walks every input vector from 0 to 2^N_IN−1 on `stim`, waits a programmable settle time per vector, and compares the DUT response `dut_out` against the ideal gate function. It reports a saturating error count, the first failing vector and a pass flag. It sits beside the gate under test in lab benches and on-chip test structures. It replaces fixed per-input clock toggling with a clocked, parametrised sweep.

---
 rtl/nand_sweep_pkg.sv | 9 +
 rtl/nand_sweep_sync.sv | 17 +
 rtl/nand_sweep_checker.sv | 95 +++++++++
 3 files changed

// File: rtl/nand_sweep_pkg.sv
// nand_sweep_pkg: shared state encoding, ideal gate model and synchroniser depth
package nand_sweep_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;
    localparam int SYNC_STAGES = 2;
    // vec is padded with ones above the live inputs so the reduction ignores them
    function automatic logic expected_out(input logic [15:0] vec, input logic invert);
        return invert ? ~&vec : &vec;
    endfunction
endpackage

// File: rtl/nand_sweep_sync.sv
// nand_sweep_sync: parametrised-depth flop synchroniser, resets to 0
module nand_sweep_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;
    // shift the input through the flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= '0;
        else ff <= (ff << 1) | STAGES'(d);
    end
    assign q = ff[STAGES-1];
endmodule

// File: rtl/nand_sweep_checker.sv
// nand_sweep_checker: exhaustive NAND/AND sweep with error count and first-fail capture (NAND_SWEEP_SYNC_EN adds an input synchroniser)
module nand_sweep_checker
    import nand_sweep_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 4,
    parameter int ERR_W  = 8,
    parameter bit INVERT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dut_out,
    output logic [N_IN-1:0]  stim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [N_IN-1:0]  first_fail_vec,
    output logic             first_fail_vld
);
`ifdef NAND_SWEEP_SYNC_EN
    localparam int WAIT_LOAD = SETTLE + 1;
    logic resp;
    nand_sweep_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (dut_out),
        .q    (resp)
    );
`else
    localparam int WAIT_LOAD = SETTLE - 1;
    logic resp;
    assign resp = dut_out;
`endif
    localparam int CW = $clog2(SETTLE + 3);
    state_t state;
    logic [CW-1:0] cnt;
    logic [15:0] vec_ext;
    logic mismatch;
    assign vec_ext = (16'hffff << N_IN) | 16'(stim);
    assign mismatch = resp != expected_out(vec_ext, INVERT);
    // sweep sequencer: hold each vector, sample, accumulate errors, report
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            stim           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_fail_vec <= '0;
            first_fail_vld <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    err_cnt        <= '0;
                    pass           <= 1'b0;
                    first_fail_vec <= '0;
                    first_fail_vld <= 1'b0;
                    stim           <= '0;
                    cnt            <= CW'(WAIT_LOAD);
                    busy           <= 1'b1;
                    state          <= WAIT;
                end
                WAIT: if (cnt == '0) state <= SAMPLE; else cnt <= cnt - 1'b1;
                SAMPLE: begin
                    if (mismatch) begin
                        if (!(&err_cnt)) err_cnt <= err_cnt + 1'b1;
                        if (!first_fail_vld) begin
                            first_fail_vec <= stim;
                            first_fail_vld <= 1'b1;
                        end
                    end
                    if (&stim) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        stim  <= stim + 1'b1;
                        cnt   <= CW'(WAIT_LOAD);
                        state <= WAIT;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    pass  <= err_cnt == '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
